fball_ctrl: RTL and testbench
=============================

FBALL_CTRL -- requirements
Module: fball_ctrl

Interface
REQ-001 SHALL have the following ports, clock and reset first.
- Clk  in  1  system clock (pixel-domain clock).
- Reset_n  in  1  reset, asynchronous assert, active-low.
- frame_clk  in  1  vsync-derived strobe; its rising edge is detected internally as frame tick.
- fire  in  1  launch request, sampled on frame tick.
- dir  in  1  launch direction: 0 = right, 1 = left.
- start_x  in  10  spawn X (top-left of sprite).
- start_y  in  10  spawn Y (top-left of sprite).
- floor_y  in  10  floor Y; the ball bottom must not pass it.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- read_address  out  9  sprite ROM address, 0..440.
- is_fball  out  1  current pixel is inside the live sprite box.
- sprite_sel  out  2  rotation frame: 0 = up, 1 = right, 2 = down, 3 = left.
- active  out  1  ball in FLY or POP.
- ball_x  out  10  current position X.
- ball_y  out  10  current position Y.
REQ-002 SHALL have these parameters:
- SIZE = 21, sprite edge in pixels.
- SPEED_X = 4, px/frame.
- GRAVITY = 1, px/frame^2.
- MAX_VY = 6.
- BOUNCE_VY = -6.
- MAX_BOUNCES = 3.
- POP_FRAMES = 8.
- SCREEN_W = 640.

Function
REQ-003 SHALL generate frame tick as a single-Clk pulse on each 0->1 transition of frame_clk, registered with one flop.
REQ-004 SHALL implement FSM states IDLE, FLY, POP; all motion and state updates SHALL occur only on frame tick.
REQ-005 IDLE: on tick with fire=1, SHALL go to FLY and load:
- x = start_x, y = start_y, vy = 0, bounces = 0.
- dir latched.
- sprite_sel = 0, rotation counter = 0.
- fire in FLY or POP SHALL be ignored.
REQ-006 FLY, per tick, SHALL update:
- x += SPEED_X (dir=0) or x -= SPEED_X (dir=1).
- vy = min(vy + GRAVITY, MAX_VY), signed 5-bit.
- y += new vy, computed 11-bit signed.
- If the y result < 0, SHALL clamp y = 0 and vy = 0.
REQ-007 Floor hit (new y + SIZE > floor_y) SHALL set y = floor_y - SIZE, vy = BOUNCE_VY, bounces += 1.
REQ-008 When bounces reaches MAX_BOUNCES, SHALL go to POP on the same tick.
REQ-009 Exit SHALL go to IDLE on the same tick. Exit conditions:
- dir=1 and x < SPEED_X before the move.
- dir=0 and x + SIZE + SPEED_X > SCREEN_W before the move.
REQ-010 Exit and floor hit on the same tick: exit SHALL take priority (IDLE, no bounce counted).
REQ-011 The rotation counter SHALL increment every tick in FLY.
- sprite_sel SHALL advance by +1 (dir=0) or -1 (dir=1) mod 4 every 4th tick.
- It SHALL hold in POP and IDLE.
REQ-012 POP SHALL hold position and count POP_FRAMES ticks, then go to IDLE; active SHALL fall on entry to IDLE.
REQ-013 Hit test SHALL be 0 <= DrawX-x < SIZE and 0 <= DrawY-y < SIZE, using unsigned 10-bit differences, with the state not IDLE.
REQ-014 On a hit, read_address SHALL = (DrawY-y)*SIZE + (DrawX-x); otherwise read_address SHALL = 0.
REQ-015 read_address and is_fball SHALL be registered with latency exactly 1 Clk from DrawX/DrawY.
REQ-016 ball_x, ball_y, active, sprite_sel SHALL be registered and change only on the Clk after a tick.
REQ-017 read_address SHALL never exceed 440.

Reset
REQ-018 Reset_n=0 SHALL asynchronously force:
- state IDLE.
- x, y, vy, bounces, rotation and pop counters = 0.
- frame_clk edge flop = 0.
- read_address = 0, is_fball = 0, sprite_sel = 0, active = 0.
REQ-019 Reset asserted mid-FLY or mid-POP SHALL abandon the ball; the first tick after release SHALL behave as IDLE.

Structure
REQ-020 Package fball_pkg SHALL hold:
- the state enum (IDLE, FLY, POP).
- all REQ-002 constants as localparams.
- the address width (9).
REQ-021 Address/hit logic (REQ-013..015) SHALL be a sub-module fball_addr_gen. It takes x, y, DrawX, DrawY and the live flag, and outputs the registered address and is_fball.

Verification
REQ-022 Launch/move: start_x=100, start_y=200, dir=0, fire, 1 tick.
- Required: active=1, ball_x=100, ball_y=200.
- Next tick: ball_x=104, ball_y=201.
- Tick after: ball_x=108, ball_y=203.
REQ-023 Address: ball at (100,200), DrawX=110, DrawY=205.
- Required: next Clk read_address=115, is_fball=1.
- With DrawX=121: is_fball=0, read_address=0.
REQ-024 Bounce: floor_y=300, ball falling with y=275, vy=6.
- Required: y=279, vy=-6, bounces=1.
- After the 3rd bounce: state POP, and IDLE exactly 8 ticks later.
REQ-025 Exit priority: dir=1, x=3, floor hit on the same tick.
- Required: IDLE, active=0, bounces unchanged.
REQ-026 Reset mid-flight: Reset_n=0 in FLY.
- Required, immediately without a Clk edge: active=0, is_fball=0, sprite_sel=0.
- fire held during the reset-release tick SHALL launch on the next tick only.
REQ-027 Rotation: dir=0, 8 FLY ticks.
- Required: sprite_sel sequence 0,0,0,0,1,1,1,1,2.
- dir=1 from 0: sprite_sel goes to 3 after 4 ticks.

Source files
------------

// File: rtl/fball_pkg.sv
// Shared constants and state encoding for the fireball controller.
// The address width covers sprite offsets 0..SIZE*SIZE-1.
package fball_pkg;

  localparam int SIZE        = 21;
  localparam int SPEED_X     = 4;
  localparam int GRAVITY     = 1;
  localparam int MAX_VY      = 6;
  localparam int BOUNCE_VY   = -6;
  localparam int MAX_BOUNCES = 3;
  localparam int POP_FRAMES  = 8;
  localparam int SCREEN_W    = 640;
  localparam int ADDR_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    POP  = 2'd2
  } state_t;

endpackage

// File: rtl/fball_addr_gen.sv
// Pixel hit test and sprite ROM address, registered one clock after DrawX/DrawY.
// Differences are unsigned, so pixels left of or above the sprite wrap and miss.
module fball_addr_gen
  import fball_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              live,
  output logic [ADDR_W-1:0] read_address,
  output logic              is_fball
);

  logic [9:0]        dx;
  logic [9:0]        dy;
  logic              hit_d, hit_q;
  logic [ADDR_W-1:0] addr_d, addr_q;

  assign dx = draw_x - x;
  assign dy = draw_y - y;

  always_comb begin
    hit_d  = live && (dx < 10'(SIZE)) && (dy < 10'(SIZE));
    addr_d = '0;
    if (hit_d) begin
      addr_d = ADDR_W'(dy) * ADDR_W'(SIZE) + ADDR_W'(dx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign read_address = addr_q;
  assign is_fball     = hit_q;

endmodule

// File: rtl/fball_ctrl.sv
// Fireball controller: launch, ballistic flight with floor bounces, pop animation.
// All motion advances on the rising edge of frame_clk, detected in the Clk domain.
module fball_ctrl
  import fball_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       dir,
  input  logic [9:0] start_x,
  input  logic [9:0] start_y,
  input  logic [9:0] floor_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [8:0] read_address,
  output logic       is_fball,
  output logic [1:0] sprite_sel,
  output logic       active,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y
);

  localparam logic signed [4:0] VY_MAX    = 5'(MAX_VY);
  localparam logic signed [4:0] VY_GRAV   = 5'(GRAVITY);
  localparam logic signed [4:0] VY_BOUNCE = 5'(BOUNCE_VY);

  state_t            state_q, state_d;
  logic              frame_q;
  logic              tick;
  logic              dir_q, dir_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic signed [4:0] vy_q, vy_d;
  logic [1:0]        bounces_q, bounces_d;
  logic [1:0]        rot_q, rot_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        pop_q, pop_d;

  logic signed [4:0] vy_inc;
  logic [11:0]       y_sum;
  logic [11:0]       y_fall;
  logic              y_neg;
  logic              floor_hit;
  logic              exit_hit;

  assign tick = frame_clk & ~frame_q;

  always_comb begin
    vy_inc    = (vy_q >= VY_MAX) ? VY_MAX : vy_q + VY_GRAV;
    y_sum     = {2'b00, y_q} + {{7{vy_inc[4]}}, vy_inc};
    y_neg     = y_sum[11];
    y_fall    = y_neg ? 12'd0 : y_sum;
    floor_hit = (y_fall + 12'(SIZE)) > {2'b00, floor_y};
    // Exit is judged on the position before this tick's move.
    exit_hit  = dir_q ? (x_q < 10'(SPEED_X))
                      : (({2'b00, x_q} + 12'(SIZE + SPEED_X)) > 12'(SCREEN_W));
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    bounces_d = bounces_q;
    rot_d     = rot_q;
    sel_d     = sel_q;
    pop_d     = pop_q;
    case (state_q)
      IDLE: begin
        if (tick && fire) begin
          state_d   = FLY;
          dir_d     = dir;
          x_d       = start_x;
          y_d       = start_y;
          vy_d      = '0;
          bounces_d = '0;
          rot_d     = '0;
          sel_d     = '0;
          pop_d     = '0;
        end
      end
      FLY: begin
        if (tick) begin
          rot_d = rot_q + 2'd1;
          if (rot_q == 2'd3) begin
            sel_d = dir_q ? sel_q - 2'd1 : sel_q + 2'd1;
          end
          if (exit_hit) begin
            state_d = IDLE;
          end else begin
            x_d = dir_q ? x_q - 10'(SPEED_X) : x_q + 10'(SPEED_X);
            if (floor_hit) begin
              y_d       = floor_y - 10'(SIZE);
              vy_d      = VY_BOUNCE;
              bounces_d = bounces_q + 2'd1;
              if (bounces_q + 2'd1 == 2'(MAX_BOUNCES)) begin
                state_d = POP;
                pop_d   = '0;
              end
            end else begin
              y_d  = y_fall[9:0];
              vy_d = y_neg ? 5'sd0 : vy_inc;
            end
          end
        end
      end
      POP: begin
        if (tick) begin
          if (pop_q == 4'(POP_FRAMES - 1)) begin
            state_d = IDLE;
            pop_d   = '0;
          end else begin
            pop_d = pop_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      frame_q   <= 1'b0;
      dir_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      vy_q      <= '0;
      bounces_q <= '0;
      rot_q     <= '0;
      sel_q     <= '0;
      pop_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_clk;
      dir_q     <= dir_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vy_q      <= vy_d;
      bounces_q <= bounces_d;
      rot_q     <= rot_d;
      sel_q     <= sel_d;
      pop_q     <= pop_d;
    end
  end

  assign active     = (state_q != IDLE);
  assign ball_x     = x_q;
  assign ball_y     = y_q;
  assign sprite_sel = sel_q;

  fball_addr_gen u_addr_gen (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .x            (x_q),
    .y            (y_q),
    .draw_x       (DrawX),
    .draw_y       (DrawY),
    .live         (active),
    .read_address (read_address),
    .is_fball     (is_fball)
  );

endmodule

// File: tb/tb_fball_ctrl.sv
// Directed bench for fball_ctrl: vector tables for addressing and trajectory,
// hand-written sequences for bounce/pop, exits, clamp, rotation and reset.
module tb_fball_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic       fire;
  logic       dir;
  logic [9:0] start_x, start_y, floor_y;
  logic [9:0] DrawX, DrawY;
  logic [8:0] read_address;
  logic       is_fball;
  logic [1:0] sprite_sel;
  logic       active;
  logic [9:0] ball_x, ball_y;

  int total;
  int bad;

  typedef struct {
    logic [9:0] dx;
    logic [9:0] dy;
    logic [8:0] addr;
    logic       hit;
  } addr_vec_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] sel;
  } traj_vec_t;

  addr_vec_t av[8];
  traj_vec_t tv[8];

  fball_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .fire         (fire),
    .dir          (dir),
    .start_x      (start_x),
    .start_y      (start_y),
    .floor_y      (floor_y),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .read_address (read_address),
    .is_fball     (is_fball),
    .sprite_sel   (sprite_sel),
    .active       (active),
    .ball_x       (ball_x),
    .ball_y       (ball_y)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // frame_clk held high for several clocks: only one tick may result
  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic launch(input logic d, input logic [9:0] sx, input logic [9:0] sy,
                        input logic [9:0] fy);
    dir = d; start_x = sx; start_y = sy; floor_y = fy;
    fire = 1'b1;
    do_tick();
    fire = 1'b0;
  endtask

  logic [8:0] prev_addr;
  logic       prev_hit;

  initial begin
    total = 0; bad = 0;
    Reset_n = 1'b1; frame_clk = 1'b0; fire = 1'b0; dir = 1'b0;
    start_x = 10'd100; start_y = 10'd200; floor_y = 10'd479;
    DrawX = 10'd0; DrawY = 10'd0;

    av[0] = '{10'd110, 10'd205, 9'd115, 1'b1};
    av[1] = '{10'd121, 10'd205, 9'd0,   1'b0};
    av[2] = '{10'd100, 10'd200, 9'd0,   1'b1};
    av[3] = '{10'd120, 10'd220, 9'd440, 1'b1};
    av[4] = '{10'd99,  10'd200, 9'd0,   1'b0};
    av[5] = '{10'd100, 10'd221, 9'd0,   1'b0};
    av[6] = '{10'd120, 10'd200, 9'd20,  1'b1};
    av[7] = '{10'd100, 10'd220, 9'd420, 1'b1};

    tv[0] = '{10'd104, 10'd201, 2'd0};
    tv[1] = '{10'd108, 10'd203, 2'd0};
    tv[2] = '{10'd112, 10'd206, 2'd0};
    tv[3] = '{10'd116, 10'd210, 2'd1};
    tv[4] = '{10'd120, 10'd215, 2'd1};
    tv[5] = '{10'd124, 10'd221, 2'd1};
    tv[6] = '{10'd128, 10'd227, 2'd1};
    tv[7] = '{10'd132, 10'd233, 2'd2};

    // reset state, checked while reset is still asserted
    #2 Reset_n = 1'b0;
    #1;
    check("rst_active", {31'd0, active}, 0);
    check("rst_is_fball", {31'd0, is_fball}, 0);
    check("rst_addr", {23'd0, read_address}, 0);
    check("rst_sel", {30'd0, sprite_sel}, 0);
    check("rst_x", {22'd0, ball_x}, 0);
    check("rst_y", {22'd0, ball_y}, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // launch; fire stays high afterwards and start_x changes, which must be ignored
    fire = 1'b1;
    do_tick();
    start_x = 10'd500;
    check("launch_active", {31'd0, active}, 1);
    check("launch_x", {22'd0, ball_x}, 100);
    check("launch_y", {22'd0, ball_y}, 200);
    check("launch_sel", {30'd0, sprite_sel}, 0);

    // address table: output must hold until the next Clk, then follow
    prev_addr = 9'd0; prev_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      DrawX = av[i].dx; DrawY = av[i].dy;
      #1;
      check($sformatf("addr_hold[%0d]", i), {23'd0, read_address}, {23'd0, prev_addr});
      check($sformatf("hit_hold[%0d]", i), {31'd0, is_fball}, {31'd0, prev_hit});
      @(negedge Clk);
      check($sformatf("addr[%0d]", i), {23'd0, read_address}, {23'd0, av[i].addr});
      check($sformatf("hit[%0d]", i), {31'd0, is_fball}, {31'd0, av[i].hit});
      prev_addr = av[i].addr; prev_hit = av[i].hit;
    end

    // trajectory and rotation table, fire still held
    for (int i = 0; i < 8; i++) begin
      do_tick();
      check($sformatf("traj_x[%0d]", i), {22'd0, ball_x}, {22'd0, tv[i].x});
      check($sformatf("traj_y[%0d]", i), {22'd0, ball_y}, {22'd0, tv[i].y});
      check($sformatf("traj_sel[%0d]", i), {30'd0, sprite_sel}, {30'd0, tv[i].sel});
    end

    // reset mid-flight: ball at (132,233), sel=2, pixel inside sprite
    start_x = 10'd100;
    DrawX = 10'd140; DrawY = 10'd240;
    repeat (2) @(negedge Clk);
    check("pre_rst_hit", {31'd0, is_fball}, 1);
    Reset_n = 1'b0;
    #1;
    check("async_active", {31'd0, active}, 0);
    check("async_is_fball", {31'd0, is_fball}, 0);
    check("async_sel", {30'd0, sprite_sel}, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("no_launch_wo_tick", {31'd0, active}, 0);
    do_tick();
    check("launch_after_rst", {31'd0, active}, 1);
    check("launch_after_rst_x", {22'd0, ball_x}, 100);
    fire = 1'b0;

    // bounce sequence: floor 300, reach y=275 vy=6, then bounce
    do_reset();
    launch(1'b0, 10'd100, 10'd254, 10'd300);
    ticks(6);
    check("fall_y", {22'd0, ball_y}, 275);
    check("fall_vy", {27'd0, dut.vy_q}, 6);
    do_tick();
    check("bounce1_y", {22'd0, ball_y}, 279);
    check("bounce1_vy", {27'd0, dut.vy_q}, 26);
    check("bounce1_cnt", {30'd0, dut.bounces_q}, 1);
    check("bounce1_x", {22'd0, ball_x}, 128);
    ticks(12);
    check("bounce2_cnt", {30'd0, dut.bounces_q}, 2);
    check("bounce2_y", {22'd0, ball_y}, 279);
    ticks(11);
    check("pre_b3_state", {30'd0, dut.state_q}, 1);
    do_tick();
    check("pop_state", {30'd0, dut.state_q}, 2);
    check("pop_active", {31'd0, active}, 1);
    check("pop_x", {22'd0, ball_x}, 224);
    ticks(7);
    check("pop7_state", {30'd0, dut.state_q}, 2);
    check("pop7_x", {22'd0, ball_x}, 224);
    check("pop7_y", {22'd0, ball_y}, 279);
    do_tick();
    check("pop8_state", {30'd0, dut.state_q}, 0);
    check("pop8_active", {31'd0, active}, 0);

    // exit priority over floor hit on the same tick
    launch(1'b1, 10'd3, 10'd290, 10'd300);
    check("exitp_launch", {31'd0, active}, 1);
    do_tick();
    check("exitp_active", {31'd0, active}, 0);
    check("exitp_state", {30'd0, dut.state_q}, 0);
    check("exitp_bounces", {30'd0, dut.bounces_q}, 0);

    // right edge: 615 still moves, 619 exits
    launch(1'b0, 10'd615, 10'd100, 10'd479);
    do_tick();
    check("rexit_move_x", {22'd0, ball_x}, 619);
    check("rexit_move_act", {31'd0, active}, 1);
    do_tick();
    check("rexit_active", {31'd0, active}, 0);

    // left edge: 4 still moves to 0, then exits
    launch(1'b1, 10'd4, 10'd100, 10'd479);
    do_tick();
    check("lexit_move_x", {22'd0, ball_x}, 0);
    check("lexit_move_act", {31'd0, active}, 1);
    do_tick();
    check("lexit_active", {31'd0, active}, 0);

    // low floor: bounce then negative y clamps to 0; dir=1 rotation to 3
    launch(1'b1, 10'd300, 10'd0, 10'd25);
    ticks(2);
    check("clamp_pre_y", {22'd0, ball_y}, 3);
    do_tick();
    check("clamp_bounce_y", {22'd0, ball_y}, 4);
    check("clamp_bounce_vy", {27'd0, dut.vy_q}, 26);
    check("rot_left_t3", {30'd0, sprite_sel}, 0);
    do_tick();
    check("clamp_y", {22'd0, ball_y}, 0);
    check("clamp_vy", {27'd0, dut.vy_q}, 0);
    check("rot_left_t4", {30'd0, sprite_sel}, 3);
    check("rot_left_x", {22'd0, ball_x}, 284);
    do_tick();
    check("clamp_next_y", {22'd0, ball_y}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
